sprite_fetch_arbiter: RTL
=========================

// Module: sprite_fetch_arbiter
// PURPOSE
//  Time-shares one RGBA sprite image reader (BRAM read + output register, 2-cycle read latency)
//  among N pixel requesters: mole sprites, hammer cursor and logo overlay.
//  Round-robin grant, one read issued per clock. Requester tag travels through a latency-matched pipeline.
//  Each response returns to its owner with an out-of-range guard. Sits between render engines and the reader.
// PARAMETERS
//  N_REQ     4    number of requesters (2..8)
//  WIDTH     45   image width in pixels
//  HEIGHT    61   image height in pixels
//  READ_LAT  2    clocks from rd_x/rd_y valid to rd_pixel valid (1..4)
// PORTS
//  clk        in   1          system clock; all logic rising-edge
//  rst        in   1          synchronous, active-high reset
//  req        in   N_REQ      per-requester read request, level; held until granted
//  req_x      in   N_REQ*10   packed X coords, requester i at [i*10+:10]
//  req_y      in   N_REQ*9    packed Y coords, requester i at [i*9+:9]
//  gnt        out  N_REQ      one-hot grant, combinational from req and rr pointer; req sampled when gnt=1
//  rd_x       out  10         X to image reader (registered)
//  rd_y       out  9          Y to image reader (registered)
//  rd_pixel   in   16         RGBA4444 from reader, valid READ_LAT clocks after rd_x/rd_y
//  rsp_valid  out  N_REQ      one-hot response strobe, one clock
//  rsp_pixel  out  16         returned pixel R[15:12] G[11:8] B[7:4] A[3:0]
//  busy       out  1          any read in flight
// BEHAVIOUR
//  - Reset: gnt=0 while rst; rd_x=0, rd_y=0, rsp_valid=0, rsp_pixel=16'h0000, busy=0, rr_ptr=0, pipeline valids cleared.
//  - Arbitration:
//    - Search starts at rr_ptr, increasing index mod N_REQ; first asserted req wins; at most one gnt bit per cycle.
//    - On grant to k: rr_ptr <= (k+1) mod N_REQ. No req: rr_ptr unchanged, no read issued.
//  - Issue (cycle T, gnt[k]=1):
//    - At T+1: rd_x/rd_y = requester k's coords, stage-0 valid=1, tag=k, oob flag latched.
//    - oob = (x>=WIDTH)||(y>=HEIGHT). An oob read drives rd_x=0, rd_y=0, so the address stays in range.
//  - Tag pipeline: valid/tag/oob delayed READ_LAT stages. Response at T+1+READ_LAT:
//    - rsp_valid[k]=1 and rsp_pixel=rd_pixel.
//    - If oob, rsp_pixel=16'h0000 (fully transparent).
//  - Total req-to-rsp latency = 1+READ_LAT clocks (3 at default). Throughput 1 pixel/clock aggregate.
//  - Responses are strictly in grant order. No back-pressure: requesters must accept rsp_valid when it fires.
//  - rsp_pixel holds its last value when rsp_valid=0.
//  - busy = OR of all pipeline valid bits.
//  - Simultaneous: new grant and response for the same or a different requester in one cycle are both legal.
//  - A requester may re-request immediately after its gnt; it competes normally in rotation.
//  - Reset mid-operation: all in-flight reads are discarded, no rsp_valid for them; first post-reset grant searches from index 0.
//  - Coord width: 10-bit X, 9-bit Y compared unsigned against WIDTH/HEIGHT.
// STRUCTURE
//  - Shared package sprite_pkg:
//    - RGBA_W=16, COORD_X_W=10, COORD_Y_W=9
//    - PIX_TRANSPARENT=16'h0000
//    - function clog2 for tag width
//  - One sub-module rr_arbiter (N_REQ param; req, ptr -> one-hot gnt, grant index).
//  - Tag/valid/oob shift pipeline and coordinate mux stay inline.
// TESTING
//  1 Single requester: req[1]=1 with x=10,y=20 at T -> gnt[1] at T; rd_x=10,rd_y=20 at T+1;
//    rsp_valid=4'b0010 at T+3 with rsp_pixel equal to the BRAM word at addr 910.
//  2 All four requesting continuously from reset -> grants 0,1,2,3,0,... one per clock;
//    responses in the same order, 3 clocks behind; no cycle has more than one rsp_valid bit set.
//  3 Out of range: req[2] with x=45,y=0, then x=0,y=61 -> rd_x=0,rd_y=0; rsp_valid[2] with rsp_pixel=16'h0000 both times.
//  4 Pointer fairness: rr_ptr=2 with req=4'b1001 -> gnt=4'b1000, then rr_ptr=0 -> gnt=4'b0001.
//  5 Reset mid-flight: grants at T and T+1, rst=1 at T+2 for one clock ->
//    no rsp_valid at T+3/T+4, busy=0 at T+3, next grant searches from 0.
//  6 Idle: req=0 for 10 clocks -> gnt=0, rsp_valid=0, busy=0, rd_x/rd_y hold their last value.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and helpers for the sprite fetch path.
// Pixel format RGBA4444, coordinate widths, transparent pixel value.
package sprite_pkg;

    localparam int RGBA_W    = 16;
    localparam int COORD_X_W = 10;
    localparam int COORD_Y_W = 9;

    localparam logic [RGBA_W-1:0] PIX_TRANSPARENT = 16'h0000;

    // Ceiling log2, used to size requester tags (result >= 1 for v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (level requests), ptr (search start index)
//        -> gnt (one-hot), idx (winner index), any (a winner exists).
module rr_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    // Walk from ptr upward (mod N_REQ); the first asserted request wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Time-shares one sprite image reader among N_REQ pixel requesters.
// Ports: clk, rst (sync, active-high); req/req_x/req_y (packed per requester);
//        gnt (one-hot, combinational); rd_x/rd_y (registered reader address);
//        rd_pixel (reader data, READ_LAT clocks after address);
//        rsp_valid (one-hot strobe), rsp_pixel (held between strobes); busy.
module sprite_fetch_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 45,
    parameter int HEIGHT   = 61,
    parameter int READ_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*COORD_X_W-1:0] req_x,
    input  logic [N_REQ*COORD_Y_W-1:0] req_y,
    output logic [N_REQ-1:0]           gnt,
    output logic [COORD_X_W-1:0]       rd_x,
    output logic [COORD_Y_W-1:0]       rd_y,
    input  logic [RGBA_W-1:0]          rd_pixel,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [RGBA_W-1:0]          rsp_pixel,
    output logic                       busy
);

    localparam int TAG_W = clog2(N_REQ);

    logic [TAG_W-1:0]     rr_ptr;
    logic [TAG_W-1:0]     gidx;
    logic [N_REQ-1:0]     arb_gnt;
    logic                 arb_any;
    logic                 issue;

    logic [COORD_X_W-1:0] sel_x;
    logic [COORD_Y_W-1:0] sel_y;
    logic                 sel_oob;

    // Stage j holds the read issued j+1 clocks ago; stage READ_LAT
    // lines up with rd_pixel.
    logic [READ_LAT:0]    pv;
    logic [READ_LAT:0]    poob;
    logic [TAG_W-1:0]     ptag [READ_LAT+1];

    logic                 fire;
    logic [RGBA_W-1:0]    rsp_data;
    logic [RGBA_W-1:0]    pix_hold;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (gidx),
        .any (arb_any)
    );

    assign gnt   = rst ? '0 : arb_gnt;
    assign issue = arb_any & ~rst;

    assign sel_x   = req_x[int'(gidx)*COORD_X_W +: COORD_X_W];
    assign sel_y   = req_y[int'(gidx)*COORD_Y_W +: COORD_Y_W];
    assign sel_oob = (int'(sel_x) >= WIDTH) || (int'(sel_y) >= HEIGHT);

    // Grant bookkeeping and reader address. An out-of-range read is
    // steered to (0,0) so the reader never sees a bad address.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            rd_x   <= '0;
            rd_y   <= '0;
        end else if (issue) begin
            if (int'(gidx) == N_REQ - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gidx + TAG_W'(1);
            end
            rd_x <= sel_oob ? '0 : sel_x;
            rd_y <= sel_oob ? '0 : sel_y;
        end
    end

    // Latency-matched valid/tag/oob pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv   <= '0;
            poob <= '0;
            for (int s = 0; s <= READ_LAT; s++) begin
                ptag[s] <= '0;
            end
        end else begin
            pv[0]   <= issue;
            poob[0] <= sel_oob;
            ptag[0] <= gidx;
            for (int s = 1; s <= READ_LAT; s++) begin
                pv[s]   <= pv[s-1];
                poob[s] <= poob[s-1];
                ptag[s] <= ptag[s-1];
            end
        end
    end

    assign fire     = pv[READ_LAT] & ~rst;
    assign rsp_data = poob[READ_LAT] ? PIX_TRANSPARENT : rd_pixel;

    always_comb begin
        rsp_valid = '0;
        if (fire) begin
            rsp_valid[ptag[READ_LAT]] = 1'b1;
        end
    end

    // rd_pixel is only meaningful in the strobe cycle, so the response
    // pixel is passed through then and held from a register otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_hold <= PIX_TRANSPARENT;
        end else if (fire) begin
            pix_hold <= rsp_data;
        end
    end

    assign rsp_pixel = fire ? rsp_data : pix_hold;
    assign busy      = (|pv) & ~rst;

endmodule
